// File: rtl/phase_seq_pkg.sv
// Shared types and constants for the phase_seq two-phase sequencer.
package phase_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_S1   = 2'b01,
        ST_S2   = 2'b10
    } state_t;

    localparam int S1_LEN_DEFAULT = 5;
    localparam int S2_LEN_DEFAULT = 12;
    localparam int LOOPS_DEFAULT  = 1;

endpackage

// File: rtl/phase_cnt.sv
// Phase cycle counter: clear has priority over enable; last flags cnt == len-1.
module phase_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] len,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign cnt  = cnt_reg;
    // len is never zero here: the sequencer maps a zero length to one on load.
    assign last = (cnt_reg == len - CNT_W'(1));

endmodule

// File: rtl/phase_seq.sv
// Runtime-configurable IDLE -> (S1 -> S2) x loops -> IDLE sequencer with abort and done pulse.
// Optional PHASE_SEQ_HOLD_EN adds a hold input that freezes progress in S1/S2.
module phase_seq
    import phase_seq_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int LOOP_W     = 4,
    parameter int S1_LEN_DEF = S1_LEN_DEFAULT,
    parameter int S2_LEN_DEF = S2_LEN_DEFAULT,
    parameter int LOOPS_DEF  = LOOPS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef PHASE_SEQ_HOLD_EN
    input  logic              hold,
`endif
    input  logic              en,
    input  logic              abort,
    input  logic              cfg_load,
    input  logic [CNT_W-1:0]  cfg_s1_len,
    input  logic [CNT_W-1:0]  cfg_s2_len,
    input  logic [LOOP_W-1:0] cfg_loops,
    output logic [1:0]        state_c,
    output logic [CNT_W-1:0]  cnt,
    output logic [LOOP_W-1:0] loop_idx,
    output logic              busy,
    output logic              done
);

    state_t            state_reg;
    logic [CNT_W-1:0]  s1_len_reg;
    logic [CNT_W-1:0]  s2_len_reg;
    logic [LOOP_W-1:0] loops_reg;
    logic [LOOP_W-1:0] loop_idx_reg;
    logic              done_reg;

    logic              hold_w;
    logic              in_phase;
    logic              advance;
    logic              last_loop;
    logic              cnt_clr;
    logic              cnt_en;
    logic              cnt_last;
    logic [CNT_W-1:0]  phase_len;

`ifdef PHASE_SEQ_HOLD_EN
    assign hold_w = hold;
`else
    assign hold_w = 1'b0;
`endif

    assign in_phase  = (state_reg == ST_S1) || (state_reg == ST_S2);
    assign phase_len = (state_reg == ST_S2) ? s2_len_reg : s1_len_reg;
    assign advance   = in_phase && !hold_w && cnt_last;
    assign last_loop = (loop_idx_reg == loops_reg - LOOP_W'(1));

    // Counter restarts on every phase boundary, in IDLE, on abort and in the illegal state.
    assign cnt_clr = abort || !in_phase || advance;
    assign cnt_en  = in_phase && !hold_w;

    phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .len   (phase_len),
        .cnt   (cnt),
        .last  (cnt_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            loop_idx_reg <= '0;
            done_reg     <= 1'b0;
            s1_len_reg   <= CNT_W'(S1_LEN_DEF);
            s2_len_reg   <= CNT_W'(S2_LEN_DEF);
            loops_reg    <= LOOP_W'(LOOPS_DEF);
        end else begin
            done_reg <= 1'b0;

            // Config loads in IDLE even alongside abort, since abort there is a no-op.
            if (state_reg == ST_IDLE && cfg_load) begin
                s1_len_reg <= (cfg_s1_len == '0) ? CNT_W'(1)  : cfg_s1_len;
                s2_len_reg <= (cfg_s2_len == '0) ? CNT_W'(1)  : cfg_s2_len;
                loops_reg  <= (cfg_loops  == '0) ? LOOP_W'(1) : cfg_loops;
            end

            if (abort) begin
                state_reg    <= ST_IDLE;
                loop_idx_reg <= '0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (en) begin
                            state_reg    <= ST_S1;
                            loop_idx_reg <= '0;
                        end
                    end
                    ST_S1: begin
                        if (advance) begin
                            state_reg <= ST_S2;
                        end
                    end
                    ST_S2: begin
                        if (advance) begin
                            if (last_loop) begin
                                state_reg    <= ST_IDLE;
                                loop_idx_reg <= '0;
                                done_reg     <= 1'b1;
                            end else begin
                                state_reg    <= ST_S1;
                                loop_idx_reg <= loop_idx_reg + LOOP_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_reg    <= ST_IDLE;
                        loop_idx_reg <= '0;
                    end
                endcase
            end
        end
    end

    assign state_c  = state_reg;
    assign loop_idx = loop_idx_reg;
    assign done     = done_reg;
    assign busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_phase_seq.sv
// Directed bench for phase_seq: default run, looped config, abort, busy-time cfg/en, zero cfg, reset.
module tb_phase_seq;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       abort;
    logic       cfg_load;
    logic [7:0] cfg_s1_len;
    logic [7:0] cfg_s2_len;
    logic [3:0] cfg_loops;
    logic [1:0] state_c;
    logic [7:0] cnt;
    logic [3:0] loop_idx;
    logic       busy;
    logic       done;
`ifdef PHASE_SEQ_HOLD_EN
    logic       hold;
`endif

    int checks = 0;
    int errors = 0;

    phase_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef PHASE_SEQ_HOLD_EN
        .hold       (hold),
`endif
        .en         (en),
        .abort      (abort),
        .cfg_load   (cfg_load),
        .cfg_s1_len (cfg_s1_len),
        .cfg_s2_len (cfg_s2_len),
        .cfg_loops  (cfg_loops),
        .state_c    (state_c),
        .cnt        (cnt),
        .loop_idx   (loop_idx),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input int s1, input int s2, input int lp);
        cfg_s1_len = 8'(s1);
        cfg_s2_len = 8'(s2);
        cfg_loops  = 4'(lp);
        cfg_load   = 1'b1;
        tick();
        cfg_load = 1'b0;
        check("cfg_load_idle_state", 32'(state_c), 0);
    endtask

    // Starts a run (en, plus any cfg_load the caller left set) and checks every cycle
    // against the closed-form schedule. poke>1 asserts cfg_load(9/9/2)+en at that cycle.
    // chain leaves the bench in the done cycle so the next run starts back-to-back.
    task automatic run(input string tag, input int s1, input int s2, input int lp,
                       input int poke, input bit chain);
        int n, p, per, e_st, e_cnt, e_li, e_done;
        per = s1 + s2;
        n   = lp * per + 1;
        en  = 1'b1;
        for (int c = 1; c <= n; c++) begin
            tick();
            if (c == 1) begin
                en = 1'b0;
                cfg_load = 1'b0;
            end
            if (c == n) begin
                e_st = 0; e_cnt = 0; e_li = 0; e_done = 1;
            end else begin
                p = c - 1;
                e_li = p / per;
                e_st = ((p % per) < s1) ? 1 : 2;
                e_cnt = ((p % per) < s1) ? (p % per) : (p % per) - s1;
                e_done = 0;
            end
            check($sformatf("%s_state_c%0d", tag, c), 32'(state_c), 32'(e_st));
            check($sformatf("%s_cnt_c%0d", tag, c), 32'(cnt), 32'(e_cnt));
            check($sformatf("%s_loop_c%0d", tag, c), 32'(loop_idx), 32'(e_li));
            check($sformatf("%s_done_c%0d", tag, c), 32'(done), 32'(e_done));
            check($sformatf("%s_busy_c%0d", tag, c), 32'(busy), 32'(e_st != 0));
            if (poke > 1 && c == poke) begin
                cfg_s1_len = 8'd9; cfg_s2_len = 8'd9; cfg_loops = 4'd2;
                cfg_load = 1'b1; en = 1'b1;
            end else if (poke > 1 && c == poke + 1) begin
                cfg_load = 1'b0; en = 1'b0;
            end
        end
        $display("run %s s1=%0d s2=%0d loops=%0d cycles=%0d", tag, s1, s2, lp, n);
        if (!chain) begin
            tick();
            check($sformatf("%s_after_state", tag), 32'(state_c), 0);
            check($sformatf("%s_after_done", tag), 32'(done), 0);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; abort = 1'b0; cfg_load = 1'b0;
        cfg_s1_len = '0; cfg_s2_len = '0; cfg_loops = '0;
`ifdef PHASE_SEQ_HOLD_EN
        hold = 1'b0;
`endif
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("rst_state", 32'(state_c), 0);
        check("rst_cnt", 32'(cnt), 0);
        check("rst_loop", 32'(loop_idx), 0);
        check("rst_done", 32'(done), 0);
        check("rst_busy", 32'(busy), 0);
        $display("reset state=%0d cnt=%0d busy=%0d", state_c, cnt, busy);

        // Defaults: S1 cycles 1-5, S2 6-17, done at 18.
        run("dflt", 5, 12, 1, 0, 1'b0);

        // Three loops of 2/3: done at cycle 16.
        load_cfg(2, 3, 3);
        run("loop3", 2, 3, 3, 0, 1'b0);

        // Abort at S2 cnt=7 with defaults (cycle 13).
        load_cfg(5, 12, 1);
        en = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            tick();
            en = 1'b0;
        end
        check("abort_pre_state", 32'(state_c), 2);
        check("abort_pre_cnt", 32'(cnt), 7);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_state", 32'(state_c), 0);
        check("abort_cnt", 32'(cnt), 0);
        check("abort_loop", 32'(loop_idx), 0);
        check("abort_done", 32'(done), 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("abort_idle_state", 32'(state_c), 0);
            check("abort_idle_done", 32'(done), 0);
        end
        $display("abort in S2 cnt=7 -> state=%0d", state_c);

        // Abort beats en in IDLE.
        abort = 1'b1; en = 1'b1;
        tick();
        abort = 1'b0; en = 1'b0;
        check("abort_vs_en_state", 32'(state_c), 0);
        $display("abort+en in IDLE -> state=%0d", state_c);

        // Abort in loop 1 of 2/3/3 (cycle 7: S1 cnt=1, loop 1).
        load_cfg(2, 3, 3);
        en = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            en = 1'b0;
        end
        check("abort2_pre_loop", 32'(loop_idx), 1);
        check("abort2_pre_cnt", 32'(cnt), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort2_state", 32'(state_c), 0);
        check("abort2_loop", 32'(loop_idx), 0);
        check("abort2_done", 32'(done), 0);
        $display("abort in loop 1 -> state=%0d loop=%0d", state_c, loop_idx);
        run("restart", 2, 3, 3, 0, 1'b0);

        // cfg_load and en while busy are ignored; this and the next run stay 5/12/1.
        load_cfg(5, 12, 1);
        run("busycfg", 5, 12, 1, 3, 1'b0);
        // Back-to-back: en during the done cycle starts S1 next cycle.
        run("b2b_a", 5, 12, 1, 0, 1'b1);
        run("b2b_b", 5, 12, 1, 0, 1'b0);

        // All-zero cfg loaded together with en: 1/1/1, done at cycle 3.
        cfg_s1_len = '0; cfg_s2_len = '0; cfg_loops = '0; cfg_load = 1'b1;
        run("zero", 1, 1, 1, 0, 1'b0);
        cfg_s1_len = 8'd3; cfg_s2_len = 8'd2; cfg_loops = 4'd2; cfg_load = 1'b1;
        run("loaden", 3, 2, 2, 0, 1'b0);

        // Reset mid-run restores defaults.
        en = 1'b1;
        tick(); en = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        check("midrst_state", 32'(state_c), 0);
        check("midrst_cnt", 32'(cnt), 0);
        check("midrst_busy", 32'(busy), 0);
        tick();
        rst_n = 1'b1;
        tick();
        $display("mid-run reset -> state=%0d", state_c);
        run("postrst", 5, 12, 1, 0, 1'b0);

`ifdef PHASE_SEQ_HOLD_EN
        // Hold for 4 cycles at S1 cnt=2 (cycle 3): done moves from 18 to 22.
        en = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            if (c == 4) hold = 1'b1;
            if (c == 8) hold = 1'b0;
            tick();
            en = 1'b0;
            if (c >= 3 && c <= 7) begin
                check("hold_cnt", 32'(cnt), 2);
                check("hold_state", 32'(state_c), 1);
            end
            if (c == 10) check("hold_s2_start", 32'(state_c), 2);
            check("hold_done", 32'(done), 32'(c == 22));
        end
        check("hold_end_state", 32'(state_c), 0);
        $display("hold 4 cycles -> done at cycle 22");
        en = 1'b1;
        tick(); en = 1'b0;
        tick();
        hold = 1'b1;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0; hold = 1'b0;
        check("hold_abort_state", 32'(state_c), 0);
        check("hold_abort_cnt", 32'(cnt), 0);
        $display("abort during hold -> state=%0d", state_c);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/phase_seq.md
# phase_seq

Parametrised two-phase sequencer that extends the fixed IDLE→S1→S2→IDLE timing block. Phase lengths and repeat count are runtime-loadable, with abort and a completion pulse. Sits between a control register interface (cfg/start/abort) and downstream logic that decodes `state_c` to gate per-phase activity.

## Interface
Parameters:
- CNT_W, 8, width of phase counter and phase length fields
- LOOP_W, 4, width of loop count field
- S1_LEN_DEF, 5, S1 length in cycles after reset
- S2_LEN_DEF, 12, S2 length in cycles after reset
- LOOPS_DEF, 1, S1+S2 repetitions per start after reset

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  start request, sampled only in IDLE
- abort  in  1  return to IDLE next cycle from any state
- cfg_load  in  1  latch cfg_* fields, honoured only in IDLE
- cfg_s1_len  in  CNT_W  S1 length in cycles
- cfg_s2_len  in  CNT_W  S2 length in cycles
- cfg_loops  in  LOOP_W  number of S1+S2 repetitions
- state_c  out  2  current state: IDLE=2'b00, S1=2'b01, S2=2'b10
- cnt  out  CNT_W  cycle index within current phase
- loop_idx  out  LOOP_W  index of current repetition, 0-based
- busy  out  1  state_c != IDLE
- done  out  1  one-cycle pulse, registered, on normal completion

## Operation
- Reset: state_c=IDLE, cnt=0, loop_idx=0, done=0, busy=0; config regs = S1_LEN_DEF, S2_LEN_DEF, LOOPS_DEF.
- Config: cfg_load in IDLE latches all three fields; ignored while busy. Value 0 in any field is treated as 1 (arithmetic in CNT_W/LOOP_W bits, no overflow).
- IDLE: en=1 and abort=0 → S1 next cycle, cnt=0, loop_idx=0. If cfg_load and en arrive in the same cycle, the new config applies to this run.
- S1: cnt increments each cycle. At cnt==s1_len-1 → S2, cnt=0.
- S2: cnt increments. At cnt==s2_len-1:
  - loop_idx==loops-1 → IDLE, cnt=0, loop_idx=0, done=1 for one cycle.
  - Otherwise → S1, cnt=0, loop_idx+1.
- Encoding 2'b11: unreachable; recovers to IDLE next cycle with cnt=0 and no done pulse.
- Abort priority: abort=1 wins over all transitions and over en. Next cycle state_c=IDLE, cnt=0, loop_idx=0, no done. Abort in IDLE is a no-op.
- en while busy is ignored and not queued.
- Reset mid-operation returns immediately to reset values and restores default config.

## Timing
- en sampled at edge t → state_c=S1 from t+1.
- S1 occupies exactly s1_len cycles; S2 occupies exactly s2_len cycles.
- Defaults: S1 for 5 cycles, S2 for 12 cycles, IDLE at t+18. done is high during cycle t+18 only.
- Back-to-back start: en asserted in the cycle done is high (state IDLE) starts S1 the following cycle.
- All outputs are registered except busy, which is decoded from state_c.

## Configuration
- PHASE_SEQ_HOLD_EN defined: adds input `hold` (1 bit).
  - hold=1 in S1/S2 freezes state_c, cnt and loop_idx.
  - abort still overrides hold.
  - hold has no effect in IDLE.
- PHASE_SEQ_HOLD_EN undefined: no `hold` port; phases always advance.

## Structure
- Package phase_seq_pkg:
  - State encodings IDLE/S1/S2 as a 2-bit typedef/localparams.
  - Default length constants.
- One sub-module, phase_cnt: loadable CNT_W up-counter with clear, enable and end-of-count flag (cnt==len-1). Instantiated once and shared across S1/S2, with the length muxed by state.

## Test plan
- Defaults, single en pulse → S1 cycles 1–5, S2 cycles 6–17, IDLE at cycle 18 with done=1 for one cycle.
- cfg_load {s1=2, s2=3, loops=3} then en → loop_idx 0,1,2, S1/S2 dwell 2/3 cycles each, single done after 15 cycles.
- abort asserted at cnt=7 in S2 → IDLE next cycle, cnt=0, loop_idx=0, done stays 0; a later en restarts cleanly.
- cfg_load while busy with s1=9 → current run unchanged (5/12); run after next en still uses 5/12.
- cfg fields all 0 → each phase lasts 1 cycle, one loop, done at cycle 3.
- (PHASE_SEQ_HOLD_EN) hold=1 for 4 cycles at S1 cnt=2 → cnt stays 2 for 4 cycles, total run extends by 4; abort during hold → IDLE next cycle.
